lvds_transmitter: RTL and testbench

LVDS_TRANSMITTER -- requirements
Module: lvds_transmitter

---
 rtl/lvds_transmitter_if.sv | 19 +
 rtl/lvds_transmitter.sv | 133 +++++++++++++
 tb/tb_lvds_transmitter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_transmitter_if.sv
// Word handshake into the LVDS transmitter.
// One-entry holding register: TXREADY means empty.
interface lvds_transmitter_if;
    logic [11:0] TXDATA;
    logic        TXVALID;
    logic        TXREADY;

    modport master (
        output TXDATA,
        output TXVALID,
        input  TXREADY
    );

    modport slave (
        input  TXDATA,
        input  TXVALID,
        output TXREADY
    );
endinterface

// File: rtl/lvds_transmitter.sv
// 12-bit word serializer: two bits per FASTCLK edge with a word frame,
// fed from a one-entry holding register, idle-word fill on underrun.
module lvds_transmitter #(
    parameter logic [11:0] IDLE_WORD = 12'h000
) (
    input  logic                FASTCLK,
    input  logic                RESET_n,
    input  logic                ENABLE,
    lvds_transmitter_if.slave   tx,
    output logic                FRAME,
    output logic                DATA_H,
    output logic                DATA_L,
    output logic [7:0]          UNDERRUN_CNT,
    output logic                BUSY
);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t      r_state;
    logic [2:0]  r_p;
    logic [11:0] r_shift;
    logic [11:0] r_hold;
    logic        r_full;
    logic [7:0]  r_cnt;
    logic [1:0]  r_sync;
    logic        r_frame;
    logic        r_dh;
    logic        r_dl;
    logic        r_busy;

    state_t      w_nxt_state;
    logic [2:0]  w_nxt_p;
    logic [11:0] w_nxt_shift;
    logic [11:0] w_word;
    logic        w_boundary;
    logic        w_load;
    logic        w_load_hold;
    logic        w_underrun;
    logic        w_nxt_send;

    // Reset asserts immediately but releases only after two clean edges.
    always_ff @(posedge FASTCLK or negedge RESET_n) begin
        if (!RESET_n) r_sync <= 2'b00;
        else          r_sync <= {r_sync[0], 1'b1};
    end

    assign w_boundary  = (r_state == S_SEND) && (r_p == 3'd5);
    assign w_load      = ENABLE && r_sync[1] &&
                         ((r_state == S_IDLE) || w_boundary);
    assign w_load_hold = w_load && r_full;
    assign w_underrun  = w_load && !r_full && (r_state == S_SEND);
    assign w_word      = r_full ? r_hold : IDLE_WORD;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_p     = r_p;
        w_nxt_shift = r_shift;
        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_nxt_state = S_SEND;
                    w_nxt_p     = 3'd0;
                    w_nxt_shift = w_word;
                end
            end
            S_SEND: begin
                if (r_p == 3'd5) begin
                    w_nxt_p = 3'd0;
                    if (w_load) begin
                        w_nxt_shift = w_word;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_shift = 12'h000;
                    end
                end else begin
                    w_nxt_p     = r_p + 3'd1;
                    w_nxt_shift = {r_shift[9:0], 2'b00};
                end
            end
        endcase
    end

    assign w_nxt_send = (w_nxt_state == S_SEND);

    always_ff @(posedge FASTCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
            r_p     <= 3'd0;
            r_shift <= 12'h000;
            r_frame <= 1'b0;
            r_dh    <= 1'b0;
            r_dl    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_p     <= w_nxt_p;
            r_shift <= w_nxt_shift;
            r_frame <= w_nxt_send && (w_nxt_p < 3'd3);
            r_dh    <= w_nxt_send && w_nxt_shift[11];
            r_dl    <= w_nxt_send && w_nxt_shift[10];
            r_busy  <= w_nxt_send;
        end
    end

    // Loading and accepting never coincide: a load needs the register full.
    always_ff @(posedge FASTCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_hold <= 12'h000;
            r_full <= 1'b0;
        end else if (w_load_hold) begin
            r_full <= 1'b0;
        end else if (tx.TXVALID && !r_full) begin
            r_hold <= tx.TXDATA;
            r_full <= 1'b1;
        end
    end

    always_ff @(posedge FASTCLK or negedge RESET_n) begin
        if (!RESET_n)                         r_cnt <= 8'h00;
        else if (w_underrun && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'h01;
    end

    assign tx.TXREADY   = !r_full;
    assign FRAME        = r_frame;
    assign DATA_H       = r_dh;
    assign DATA_L       = r_dl;
    assign UNDERRUN_CNT = r_cnt;
    assign BUSY         = r_busy;

endmodule

// File: tb/tb_lvds_transmitter.sv
// Scoreboard bench for lvds_transmitter: accepted words are queued
// and compared against the deserialized output stream word by word.
module tb_lvds_transmitter;

    localparam logic [11:0] IDLE_W = 12'h3C6;

    logic       FASTCLK;
    logic       RESET_n;
    logic       ENABLE;
    logic       FRAME;
    logic       DATA_H;
    logic       DATA_L;
    logic [7:0] UNDERRUN_CNT;
    logic       BUSY;

    lvds_transmitter_if tx_if ();

    lvds_transmitter #(.IDLE_WORD(IDLE_W)) dut (
        .FASTCLK      (FASTCLK),
        .RESET_n      (RESET_n),
        .ENABLE       (ENABLE),
        .tx           (tx_if),
        .FRAME        (FRAME),
        .DATA_H       (DATA_H),
        .DATA_L       (DATA_L),
        .UNDERRUN_CNT (UNDERRUN_CNT),
        .BUSY         (BUSY)
    );

    int          errs   = 0;
    int          checks = 0;
    logic [11:0] q[$];
    logic [11:0] exp_w;
    logic [11:0] acc;
    logic [5:0]  fr;
    logic [7:0]  exp_cnt = 8'h00;
    int          pc     = 0;
    bit          first  = 1'b1;
    int          nwords = 0;

    initial FASTCLK = 1'b0;
    always #5 FASTCLK = ~FASTCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Deserializer and scoreboard consumer.
    always @(negedge FASTCLK) begin
        if (!RESET_n || !BUSY) begin
            pc    = 0;
            first = 1'b1;
        end else begin
            if (pc == 0) begin
                if (q.size() > 0) begin
                    exp_w = q.pop_front();
                end else begin
                    exp_w = IDLE_W;
                    if (!first && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
                end
                first = 1'b0;
                chk("underrun_cnt", UNDERRUN_CNT, exp_cnt);
                acc = 12'h000;
                fr  = 6'h00;
            end
            acc = {acc[9:0], DATA_H, DATA_L};
            fr  = {fr[4:0], FRAME};
            if (pc == 5) begin
                chk("word", acc, exp_w);
                chk("frame", fr, 6'b111000);
                nwords++;
            end
            pc = (pc == 5) ? 0 : pc + 1;
        end
    end

    // Called at a negedge; returns at a negedge after the transfer.
    task automatic send_word(input logic [11:0] w);
        int   n;
        bit   done;
        logic rdy;
        n    = 0;
        done = 1'b0;
        tx_if.TXDATA  = w;
        tx_if.TXVALID = 1'b1;
        while (!done && n < 200) begin
            rdy = tx_if.TXREADY;
            @(posedge FASTCLK);
            if (rdy) begin
                q.push_back(w);
                done = 1'b1;
            end
            @(negedge FASTCLK);
            n++;
        end
        tx_if.TXVALID = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic v);
        int n;
        n = 0;
        while (BUSY !== v && n < 100) begin
            @(negedge FASTCLK);
            n++;
        end
        chk("busy_wait", BUSY, v);
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (tx_if.TXREADY !== 1'b1 && n < 100) begin
            @(negedge FASTCLK);
            n++;
        end
        chk("ready_wait", tx_if.TXREADY, 1'b1);
    endtask

    initial begin
        RESET_n       = 1'b0;
        ENABLE        = 1'b0;
        tx_if.TXDATA  = 12'h000;
        tx_if.TXVALID = 1'b0;
        #1;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ready", tx_if.TXREADY, 1'b1);
        chk("rst_frame", FRAME, 1'b0);
        chk("rst_data", {DATA_H, DATA_L}, 2'b00);
        chk("rst_cnt", UNDERRUN_CNT, 8'h00);
        repeat (3) @(negedge FASTCLK);
        RESET_n = 1'b1;
        repeat (4) @(negedge FASTCLK);

        // Single word, idle-accepted then enabled.
        send_word(12'hA5C);
        chk("held_ready", tx_if.TXREADY, 1'b0);
        ENABLE = 1'b1;
        wait_busy(1'b1);
        ENABLE = 1'b0;
        wait_busy(1'b0);
        chk("single_ready", tx_if.TXREADY, 1'b1);

        // Back-to-back words with TXVALID held.
        send_word(12'hFFF);
        ENABLE = 1'b1;
        send_word(12'h001);
        send_word(12'h800);
        wait_ready();
        ENABLE = 1'b0;
        wait_busy(1'b0);
        chk("b2b_cnt", UNDERRUN_CNT, 8'h00);

        // Long underrun saturates the counter.
        ENABLE = 1'b1;
        repeat (300 * 6) @(negedge FASTCLK);
        ENABLE = 1'b0;
        wait_busy(1'b0);
        chk("sat_cnt", UNDERRUN_CNT, 8'hFF);

        // Reset clears the counter before the next scenarios.
        RESET_n = 1'b0;
        exp_cnt = 8'h00;
        @(negedge FASTCLK);
        RESET_n = 1'b1;
        repeat (4) @(negedge FASTCLK);

        // Disable mid-word keeps the word whole and the held word.
        send_word(12'h5A3);
        ENABLE = 1'b1;
        wait_busy(1'b1);
        send_word(12'h96E);
        @(negedge FASTCLK);
        ENABLE = 1'b0;
        repeat (3) @(negedge FASTCLK);
        chk("dis_busy_p5", BUSY, 1'b1);
        @(negedge FASTCLK);
        chk("dis_idle", BUSY, 1'b0);
        chk("dis_held", tx_if.TXREADY, 1'b0);
        ENABLE = 1'b1;
        wait_busy(1'b1);
        ENABLE = 1'b0;
        wait_busy(1'b0);

        // Asynchronous reset mid-word drops both words.
        send_word(12'h123);
        ENABLE = 1'b1;
        wait_busy(1'b1);
        send_word(12'hC3D);
        repeat (2) @(negedge FASTCLK);
        #2;
        RESET_n = 1'b0;
        ENABLE  = 1'b0;
        #1;
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_frame", FRAME, 1'b0);
        chk("arst_data", {DATA_H, DATA_L}, 2'b00);
        chk("arst_ready", tx_if.TXREADY, 1'b1);
        q.delete();
        exp_cnt = 8'h00;
        repeat (2) @(negedge FASTCLK);
        RESET_n = 1'b1;
        repeat (4) @(negedge FASTCLK);

        // Restart after reset streams only idle words.
        ENABLE = 1'b1;
        wait_busy(1'b1);
        repeat (12) @(negedge FASTCLK);
        ENABLE = 1'b0;
        wait_busy(1'b0);
        chk("post_cnt", UNDERRUN_CNT, exp_cnt);
        chk("queue_empty", q.size(), 0);
        chk("words_seen", (nwords > 300), 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
